// File: rtl/flag_cond_unit_pkg.sv
// Shared condition-code and NZVC bit-index definitions for the status-flag unit
// and anything else that decodes branch conditions.
package flag_cond_unit_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  // Merge an ALU flag vector into the current flags under a per-bit enable.
  function automatic logic [3:0] merge_flags(input logic [3:0] cur,
                                             input logic [3:0] upd,
                                             input logic [3:0] mask);
    return (cur & ~mask) | (upd & mask);
  endfunction

endpackage

// File: rtl/flag_cond_unit_cond_eval.sv
// Combinational branch-condition evaluator: maps a 4-bit condition code and
// an NZVC vector to a taken/not-taken decision.
module flag_cond_unit_cond_eval
  import flag_cond_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzvc,
  output logic       taken
);

  logic n_s, z_s, v_s, c_s;

  assign n_s = nzvc[FLAG_N];
  assign z_s = nzvc[FLAG_Z];
  assign v_s = nzvc[FLAG_V];
  assign c_s = nzvc[FLAG_C];

  // Condition decode.
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = z_s;
      COND_NE: taken = !z_s;
      COND_CS: taken = c_s;
      COND_CC: taken = !c_s;
      COND_MI: taken = n_s;
      COND_PL: taken = !n_s;
      COND_VS: taken = v_s;
      COND_VC: taken = !v_s;
      COND_HI: taken = c_s & !z_s;
      COND_LS: taken = !c_s | z_s;
      COND_GE: taken = (n_s == v_s);
      COND_LT: taken = (n_s != v_s);
      COND_GT: taken = !z_s & (n_s == v_s);
      COND_LE: taken = z_s | (n_s != v_s);
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_cond_unit.sv
// Architectural NZVC status register with carry feedback, a one-entry branch
// resolution stage on a valid/ready handshake, and a LIFO of saved flags.
module flag_cond_unit
  import flag_cond_unit_pkg::*;
#(
  parameter int STACK_DEPTH = 4,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        alu_nzvc,
  input  logic              flag_we,
  input  logic [3:0]        flag_mask,
  output logic [3:0]        nzvc,
  output logic              cin,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [3:0]        br_cond,
  input  logic [ADDR_W-1:0] br_target,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_taken,
  output logic [ADDR_W-1:0] res_target,
  input  logic              irq_push,
  input  logic              irq_pop,
  output logic              stk_empty,
  output logic              stk_full,
  output logic              stk_err
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [3:0]        nzvc_q, nzvc_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d, ptr_m1_s;
  logic [3:0]        stack_q [STACK_DEPTH];
  logic [3:0]        stack_d [STACK_DEPTH];
  logic              err_q, err_d;
  logic              res_valid_q, res_valid_d;
  logic              res_taken_q, res_taken_d;
  logic [ADDR_W-1:0] res_target_q, res_target_d;
  logic              push_ok_s, pop_ok_s, accept_s, taken_s;

  assign stk_empty = (ptr_q == {PTR_W{1'b0}});
  assign stk_full  = (ptr_q == PTR_W'(STACK_DEPTH));
  assign ptr_m1_s  = ptr_q - PTR_W'(1);
  assign push_ok_s = irq_push & !irq_pop & !stk_full;
  assign pop_ok_s  = irq_pop & !irq_push & !stk_empty;
  assign br_ready  = !res_valid_q | res_ready;
  assign accept_s  = br_valid & br_ready;

  // Next flags, pointer, stack contents and sticky error.
  always_comb begin
    nzvc_d  = nzvc_q;
    ptr_d   = ptr_q;
    stack_d = stack_q;
    err_d   = err_q;
    if (pop_ok_s) begin
      nzvc_d = stack_q[ptr_m1_s[IDX_W-1:0]];
      ptr_d  = ptr_m1_s;
    end else if (flag_we) begin
      nzvc_d = merge_flags(nzvc_q, alu_nzvc, flag_mask);
    end else begin
      nzvc_d = nzvc_q;
    end
    if (push_ok_s) begin
      stack_d[ptr_q[IDX_W-1:0]] = nzvc_q;
      ptr_d = ptr_q + PTR_W'(1);
    end else begin
      ptr_d = ptr_d;
    end
    if ((irq_push & irq_pop) | (irq_push & stk_full) | (irq_pop & stk_empty)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Branches see the flags as they will be after this edge (bypass).
  flag_cond_unit_cond_eval u_cond_eval (
    .cond  (br_cond),
    .nzvc  (nzvc_d),
    .taken (taken_s)
  );

  // Result register: load on accept, drop when consumed.
  always_comb begin
    res_valid_d  = res_valid_q;
    res_taken_d  = res_taken_q;
    res_target_d = res_target_q;
    if (accept_s) begin
      res_valid_d  = 1'b1;
      res_taken_d  = taken_s;
      res_target_d = br_target;
    end else if (res_ready) begin
      res_valid_d  = 1'b0;
    end else begin
      res_valid_d  = res_valid_q;
    end
  end

  // Control and status state.
  always_ff @(posedge clk) begin
    if (rst) begin
      nzvc_q       <= 4'b0000;
      ptr_q        <= {PTR_W{1'b0}};
      err_q        <= 1'b0;
      res_valid_q  <= 1'b0;
      res_taken_q  <= 1'b0;
      res_target_q <= {ADDR_W{1'b0}};
    end else begin
      nzvc_q       <= nzvc_d;
      ptr_q        <= ptr_d;
      err_q        <= err_d;
      res_valid_q  <= res_valid_d;
      res_taken_q  <= res_taken_d;
      res_target_q <= res_target_d;
    end
  end

  // Stack storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign nzvc       = nzvc_q;
  assign cin        = nzvc_q[FLAG_C];
  assign res_valid  = res_valid_q;
  assign res_taken  = res_taken_q;
  assign res_target = res_target_q;
  assign stk_err    = err_q;

endmodule

// File: tb/tb_flag_cond_unit.sv
// Directed self-checking bench for flag_cond_unit.
module tb_flag_cond_unit;

  logic        clk = 1'b0;
  logic        rst, flag_we, br_valid, res_ready, irq_push, irq_pop;
  logic [3:0]  alu_nzvc, flag_mask, br_cond, nzvc;
  logic [15:0] br_target, res_target;
  logic        cin, br_ready, res_valid, res_taken, stk_empty, stk_full, stk_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flag_cond_unit #(.STACK_DEPTH(4), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .alu_nzvc(alu_nzvc), .flag_we(flag_we),
    .flag_mask(flag_mask), .nzvc(nzvc), .cin(cin), .br_valid(br_valid),
    .br_ready(br_ready), .br_cond(br_cond), .br_target(br_target),
    .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
    .res_target(res_target), .irq_push(irq_push), .irq_pop(irq_pop),
    .stk_empty(stk_empty), .stk_full(stk_full), .stk_err(stk_err)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_flags(input logic [3:0] v);
    flag_we = 1'b1; flag_mask = 4'b1111; alu_nzvc = v;
    tick();
    flag_we = 1'b0;
  endtask

  logic [3:0] push_vals [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0000};
  logic [3:0] pop_vals  [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
  logic [3:0] conds     [5] = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd15};
  logic       exp_tk    [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    rst = 1'b1; flag_we = 1'b0; flag_mask = 4'b0000; alu_nzvc = 4'b0000;
    br_valid = 1'b0; br_cond = 4'd0; br_target = 16'h0000; res_ready = 1'b1;
    irq_push = 1'b0; irq_pop = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_nzvc", {12'h000, nzvc}, 16'h0000);
    check("rst_cin", {15'h0, cin}, 16'h0000);
    check("rst_res_valid", {15'h0, res_valid}, 16'h0000);
    check("rst_res_taken", {15'h0, res_taken}, 16'h0000);
    check("rst_res_target", res_target, 16'h0000);
    check("rst_empty", {15'h0, stk_empty}, 16'h0001);
    check("rst_full", {15'h0, stk_full}, 16'h0000);
    check("rst_err", {15'h0, stk_err}, 16'h0000);
    check("rst_br_ready", {15'h0, br_ready}, 16'h0001);

    // Full and masked status writes.
    write_flags(4'b0101);
    check("wr1_nzvc", {12'h000, nzvc}, 16'h0005);
    check("wr1_cin", {15'h0, cin}, 16'h0001);
    flag_we = 1'b1; flag_mask = 4'b1100; alu_nzvc = 4'b1010;
    tick();
    flag_we = 1'b0;
    check("wr2_nzvc", {12'h000, nzvc}, 16'h0009);
    check("wr2_cin", {15'h0, cin}, 16'h0001);

    // Signed conditions with N=1, V=1, back to back.
    write_flags(4'b1010);
    check("cin_clear", {15'h0, cin}, 16'h0000);
    br_valid = 1'b1; br_target = 16'h00A0;
    for (int i = 0; i < 5; i++) begin
      br_cond = conds[i];
      check("cond_br_ready", {15'h0, br_ready}, 16'h0001);
      tick();
      check("cond_valid", {15'h0, res_valid}, 16'h0001);
      check("cond_taken", {15'h0, res_taken}, {15'h0, exp_tk[i]});
      check("cond_target", res_target, 16'h00A0);
    end
    br_valid = 1'b0;
    tick();
    check("drain_valid", {15'h0, res_valid}, 16'h0000);

    // Same-edge flag write feeds the branch decision.
    write_flags(4'b0000);
    flag_we = 1'b1; flag_mask = 4'b1111; alu_nzvc = 4'b0100;
    br_valid = 1'b1; br_cond = 4'd0; br_target = 16'h1234;
    tick();
    flag_we = 1'b0; br_valid = 1'b0;
    check("byp_taken", {15'h0, res_taken}, 16'h0001);
    check("byp_target", res_target, 16'h1234);
    check("byp_nzvc", {12'h000, nzvc}, 16'h0004);
    tick();
    check("byp_drain", {15'h0, res_valid}, 16'h0000);

    // Backpressure: result holds while the next request waits.
    res_ready = 1'b0; br_valid = 1'b1; br_cond = 4'd14; br_target = 16'h1111;
    tick();
    br_cond = 4'd15; br_target = 16'h2222;
    for (int i = 0; i < 3; i++) begin
      check("bp_br_ready", {15'h0, br_ready}, 16'h0000);
      check("bp_target", res_target, 16'h1111);
      check("bp_taken", {15'h0, res_taken}, 16'h0001);
      tick();
    end
    res_ready = 1'b1;
    #1;
    check("bp_release_ready", {15'h0, br_ready}, 16'h0001);
    tick();
    br_valid = 1'b0;
    check("bp_second_valid", {15'h0, res_valid}, 16'h0001);
    check("bp_second_target", res_target, 16'h2222);
    check("bp_second_taken", {15'h0, res_taken}, 16'h0000);
    tick();
    check("bp_empty", {15'h0, res_valid}, 16'h0000);

    // Stack fill: each push saves the pre-update flags.
    write_flags(4'b0001);
    for (int i = 0; i < 4; i++) begin
      irq_push = 1'b1; flag_we = 1'b1; flag_mask = 4'b1111; alu_nzvc = push_vals[i];
      tick();
    end
    irq_push = 1'b0; flag_we = 1'b0;
    check("stk_full", {15'h0, stk_full}, 16'h0001);
    check("stk_err_clean", {15'h0, stk_err}, 16'h0000);
    irq_push = 1'b1; flag_we = 1'b1; alu_nzvc = 4'b0011;
    tick();
    irq_push = 1'b0; flag_we = 1'b0;
    check("ovf_err", {15'h0, stk_err}, 16'h0001);
    check("ovf_full", {15'h0, stk_full}, 16'h0001);
    check("ovf_nzvc", {12'h000, nzvc}, 16'h0003);
    for (int i = 0; i < 4; i++) begin
      irq_pop = 1'b1; flag_we = 1'b1; alu_nzvc = 4'b1111;
      tick();
      check("pop_nzvc", {12'h000, nzvc}, {12'h000, pop_vals[i]});
    end
    irq_pop = 1'b0; flag_we = 1'b0;
    check("pop_empty", {15'h0, stk_empty}, 16'h0001);
    check("pop_not_full", {15'h0, stk_full}, 16'h0000);

    // Simultaneous push/pop: stack untouched, flag write still lands.
    irq_push = 1'b1;
    tick();
    irq_pop = 1'b1; flag_we = 1'b1; alu_nzvc = 4'b1111;
    tick();
    irq_push = 1'b0; irq_pop = 1'b0; flag_we = 1'b0;
    check("pp_nzvc", {12'h000, nzvc}, 16'h000F);
    check("pp_err", {15'h0, stk_err}, 16'h0001);
    check("pp_not_empty", {15'h0, stk_empty}, 16'h0000);
    irq_pop = 1'b1;
    tick();
    irq_pop = 1'b0;
    check("pp_pop_nzvc", {12'h000, nzvc}, 16'h0001);
    check("pp_pop_empty", {15'h0, stk_empty}, 16'h0001);

    // Reset with a pending result.
    res_ready = 1'b0; br_valid = 1'b1; br_cond = 4'd14; br_target = 16'h5555;
    tick();
    br_valid = 1'b0;
    check("pre_rst_valid", {15'h0, res_valid}, 16'h0001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", {15'h0, res_valid}, 16'h0000);
    check("mid_rst_err", {15'h0, stk_err}, 16'h0000);
    check("mid_rst_nzvc", {12'h000, nzvc}, 16'h0000);
    check("mid_rst_target", res_target, 16'h0000);
    check("mid_rst_br_ready", {15'h0, br_ready}, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
